// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared constants and helpers for the BRAM-backed FIFO controller and its output stage.
package bram_fifo_ctrl_pkg;

  // Port-B read data arrives this many cycles after mem_enb.
  localparam int RD_LATENCY = 1;
  // Entries in the output staging buffer.
  localparam int OBUF_DEPTH = 2;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bram_fifo_ctrl_out_stage.sv
// Two-entry output staging buffer plus tracking of reads still travelling through the memory.
module fifo_out_stage
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  pop,
  input  logic                  rd_issue,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic                  inflight
);

  logic [RD_LATENCY-1:0] pipe_reg;
  logic [RD_LATENCY-1:0] pipe_next;
  logic [1:0]            occ_reg;
  logic [1:0]            occ_next;
  logic [1:0]            occ_after_pop;
  logic                  arrive;
  logic [DATA_WIDTH-1:0] slot_reg  [OBUF_DEPTH];
  logic [DATA_WIDTH-1:0] slot_next [OBUF_DEPTH];

  genvar gi;

  assign pipe_next[0] = rd_issue;
  for (gi = 1; gi < RD_LATENCY; gi++) begin : g_pipe
    assign pipe_next[gi] = pipe_reg[gi-1];
  end

  assign arrive        = pipe_reg[RD_LATENCY-1];
  assign inflight      = |pipe_reg;
  assign occ_after_pop = occ_reg - {1'b0, pop};
  assign occ_next      = occ_after_pop + {1'b0, arrive};

  // Slot 0 is always the head; a pop shifts everything down one place and
  // arriving read data lands in the first free slot after that shift.
  for (gi = 0; gi < OBUF_DEPTH; gi++) begin : g_slot
    localparam logic [1:0] SLOT = 2'(gi);
    logic [DATA_WIDTH-1:0] shifted;
    if (gi < OBUF_DEPTH - 1) begin : g_shift
      assign shifted = pop ? slot_reg[gi+1] : slot_reg[gi];
    end else begin : g_last
      assign shifted = slot_reg[gi];
    end
    assign slot_next[gi] = (arrive && (occ_after_pop == SLOT)) ? rd_data : shifted;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_reg <= '0;
      occ_reg  <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) slot_reg[i] <= '0;
    end else if (flush) begin
      pipe_reg <= '0;
      occ_reg  <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) slot_reg[i] <= '0;
    end else begin
      pipe_reg <= pipe_next;
      occ_reg  <= occ_next;
      for (int i = 0; i < OBUF_DEPTH; i++) slot_reg[i] <= slot_next[i];
    end
  end

  assign out_valid = (occ_reg != 2'd0);
  assign out_data  = slot_reg[0];
  assign occupancy = occ_reg;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller around an external dual-port RAM: port A writes, port B reads into a staging buffer.
module bram_fifo_ctrl
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  input  logic                      out_ready,
  output logic [clog2(DEPTH):0]     count,
  output logic                      mem_ena,
  output logic                      mem_wea,
  output logic [clog2(DEPTH)-1:0]   mem_addra,
  output logic [DATA_WIDTH-1:0]     mem_dina,
  output logic                      mem_enb,
  output logic [clog2(DEPTH)-1:0]   mem_addrb,
  input  logic [DATA_WIDTH-1:0]     mem_doutb
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] mem_cnt_reg, mem_cnt_next;
  logic [CW-1:0] count_reg, count_next;
  logic          push;
  logic          pop;
  logic          rd_issue;
  logic [1:0]    obuf_occ;
  logic          obuf_inflight;
  logic [2:0]    obuf_level;

  // Gated by rst so nothing is accepted while the block is held in reset.
  assign in_ready = rst & (count_reg != FULL_COUNT) & ~flush;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready & ~flush;

  // A read is only launched when its data is guaranteed a staging slot on arrival.
  assign obuf_level = {1'b0, obuf_occ} + {2'b00, obuf_inflight};
  assign rd_issue   = (mem_cnt_reg != '0) & ~flush &
                      (obuf_level < (3'(OBUF_DEPTH) + {2'b00, pop}));

  assign mem_ena   = push;
  assign mem_wea   = push;
  assign mem_addra = wr_ptr_reg;
  assign mem_dina  = in_data;
  assign mem_enb   = rd_issue;
  assign mem_addrb = rd_ptr_reg;
  assign count     = count_reg;

  // mem_cnt only sees a write after its edge, so port B never reads a word in its write cycle.
  always_comb begin
    wr_ptr_next  = wr_ptr_reg + AW'(push);
    rd_ptr_next  = rd_ptr_reg + AW'(rd_issue);
    mem_cnt_next = mem_cnt_reg + CW'(push) - CW'(rd_issue);
    count_next   = count_reg + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      mem_cnt_reg <= '0;
      count_reg   <= '0;
    end else if (flush) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      mem_cnt_reg <= '0;
      count_reg   <= '0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      mem_cnt_reg <= mem_cnt_next;
      count_reg   <= count_next;
    end
  end

  fifo_out_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .pop       (pop),
    .rd_issue  (rd_issue),
    .rd_data   (mem_doutb),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occupancy (obuf_occ),
    .inflight  (obuf_inflight)
  );

endmodule
